// File: rtl/jk_bank_sequencer.sv
// Two-port round-robin sequencer that applies masked JK operations to a shared bank of JK bits.
// A granted command drives J/K for len+1 cycles, then signals completion for one cycle.
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [WIDTH-1:0] mask_a,
  input  logic [3:0]       len_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] mask_b,
  input  logic [3:0]       len_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StDone
  } state_e;

  state_e           state_q, state_d;
  // Requester identity encoding: 0 = A, 1 = B.
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [1:0]       cmd_op_q, cmd_op_d;
  logic [WIDTH-1:0] cmd_mask_q, cmd_mask_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic grant_a, grant_b;
  logic accept;

  // Round-robin: a lone requester wins; on a tie the one that did not win last time goes.
  always_comb begin
    grant_a = req_a & (~req_b | last_q);
    grant_b = req_b & (~req_a | ~last_q);
    ack_a   = (state_q == StIdle) & grant_a;
    ack_b   = (state_q == StIdle) & grant_b;
    accept  = ack_a | ack_b;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StApply;
        end
      end
      StApply: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    j       = '0;
    k       = '0;
    busy    = 1'b0;
    done    = 1'b0;
    done_id = 1'b0;
    unique case (state_q)
      StApply: begin
        j    = cmd_mask_q & {WIDTH{cmd_op_q[1]}};
        k    = cmd_mask_q & {WIDTH{cmd_op_q[0]}};
        busy = 1'b1;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        done_id = owner_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Command capture on accept and repeat-count bookkeeping.
  always_comb begin
    last_d     = last_q;
    owner_d    = owner_q;
    cmd_op_d   = cmd_op_q;
    cmd_mask_d = cmd_mask_q;
    cnt_d      = cnt_q;
    if (accept) begin
      last_d     = ack_b;
      owner_d    = ack_b;
      cmd_op_d   = ack_b ? op_b : op_a;
      cmd_mask_d = ack_b ? mask_b : mask_a;
      cnt_d      = ack_b ? len_b : len_a;
    end else if (state_q == StApply && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      cmd_op_q   <= '0;
      cmd_mask_q <= '0;
      cnt_q      <= '0;
    end else begin
      last_q     <= last_d;
      owner_q    <= owner_d;
      cmd_op_q   <= cmd_op_d;
      cmd_mask_q <= cmd_mask_d;
      cnt_q      <= cnt_d;
    end
  end

  // JK characteristic equation: q+ = J & ~q | ~K & q.
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  ack_onehot: assert property (@(posedge clk) disable iff (!reset) !(ack_a && ack_b));
  ack_idle_only: assert property (@(posedge clk) disable iff (!reset)
                                  (ack_a || ack_b) |-> !busy);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: reset, set, toggle, arbitration, empty mask and abort.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_jk_bank_sequencer;

  logic       clk;
  logic       reset;
  logic       req_a, req_b;
  logic [1:0] op_a, op_b;
  logic [7:0] mask_a, mask_b;
  logic [3:0] len_a, len_b;
  logic       ack_a, ack_b;
  logic [7:0] j, k, q;
  logic       busy, done, done_id;

  int checks = 0;
  int errors = 0;

  jk_bank_sequencer #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_a   (req_a),
    .op_a    (op_a),
    .mask_a  (mask_a),
    .len_a   (len_a),
    .req_b   (req_b),
    .op_b    (op_b),
    .mask_b  (mask_b),
    .len_b   (len_b),
    .ack_a   (ack_a),
    .ack_b   (ack_b),
    .j       (j),
    .k       (k),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .done_id (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command and wait for its completion; leaves the DUT idle.
  task automatic run_op(input bit who, input logic [1:0] op, input logic [7:0] mask,
                        input logic [3:0] len);
    bit got;
    @(negedge clk);
    if (who) begin
      req_b = 1'b1; op_b = op; mask_b = mask; len_b = len;
    end else begin
      req_a = 1'b1; op_a = op; mask_a = mask; len_a = len;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((who ? ack_b : ack_a) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL run_op_ack: no ack within 20 cycles (required ack=1)");
    end
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL run_op_done: no done within 40 cycles (required done=1)");
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({q, j, k, busy, done, done_id} !== {8'h00, 8'h00, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: q=%h j=%h k=%h busy=%b done=%b id=%b (required all 0)",
               q, j, k, busy, done, done_id);
    end
    @(negedge clk);
    reset = 1'b1;
    req_a = 1'b1; op_a = 2'b10; mask_a = 8'hA5; len_a = 4'd3;
    #1;
    checks++;
    if (ack_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_ack: ack_a=%b (required 1)", ack_a);
    end
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (q !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: q=%h busy=%b (required A5 1)", q, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({q, busy, done, ack_a, ack_b, j} !== {8'h00, 4'b0000, 8'h00}) begin
      errors++;
      $display("FAIL reset_midrun: q=%h busy=%b done=%b ack=%b%b j=%h (required 00 0 0 00 00)",
               q, busy, done, ack_a, ack_b, j);
    end
    @(negedge clk);
    reset = 1'b1;
    // Reset must restore last=B, so A wins this tie even though A was the last winner.
    req_a = 1'b1; req_b = 1'b1;
    op_b = 2'b11; mask_b = 8'hFF; len_b = 4'd0;
    #1;
    checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_tie: ack_a=%b ack_b=%b (required 1 0)", ack_a, ack_b);
    end
    // Withdraw before the edge: nothing may change.
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_set;
    @(negedge clk);
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL set_withdraw: q=%h busy=%b (required 00 0)", q, busy);
    end
    req_a = 1'b1; op_a = 2'b10; mask_a = 8'h0F; len_a = 4'd0;
    #1;
    checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL set_ack: ack_a=%b ack_b=%b (required 1 0)", ack_a, ack_b);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({ack_a, busy, j, k, q} !== {2'b01, 8'h0F, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL set_apply: ack_a=%b busy=%b j=%h k=%h q=%h (required 0 1 0F 00 00)",
               ack_a, busy, j, k, q);
    end
    req_a = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({q, done, done_id, busy, j} !== {8'h0F, 3'b101, 8'h00}) begin
      errors++;
      $display("FAIL set_done: q=%h done=%b id=%b busy=%b j=%h (required 0F 1 0 1 00)",
               q, done, done_id, busy, j);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL set_idle: busy=%b done=%b (required 0 0)", busy, done);
    end
  endtask

  task automatic test_toggle;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'hF0; exp_q[1] = 8'h0F; exp_q[2] = 8'hF0;
    @(negedge clk);
    req_b = 1'b1; op_b = 2'b11; mask_b = 8'hFF; len_b = 4'd2;
    #1;
    checks++;
    if (ack_b !== 1'b1) begin
      errors++;
      $display("FAIL toggle_ack: ack_b=%b (required 1)", ack_b);
    end
    @(negedge clk);
    req_b = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      checks++;
      if (q !== exp_q[t]) begin
        errors++;
        $display("FAIL toggle_q%0d: q=%h (required %h)", t, q, exp_q[t]);
      end
    end
    checks++;
    if (done !== 1'b1 || done_id !== 1'b1) begin
      errors++;
      $display("FAIL toggle_done: done=%b id=%b (required 1 1)", done, done_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL toggle_idle: busy=%b (required 0)", busy);
    end
  endtask

  task automatic test_held;
    int n_acks = 0;
    int last_cyc = 0;
    bit last_id = 1'b0;
    bit got;
    @(negedge clk);
    op_a = 2'b00; mask_a = 8'hFF; len_a = 4'd1;
    op_b = 2'b00; mask_b = 8'hFF; len_b = 4'd2;
    req_a = 1'b1; req_b = 1'b1;
    for (int cyc = 0; cyc < 60 && n_acks < 4; cyc++) begin
      #1;
      if ((ack_a | ack_b) && busy) begin
        checks++; errors++;
        $display("FAIL held_ack_busy: ack while busy at cycle %0d", cyc);
      end
      if (ack_a | ack_b) begin
        checks++;
        if (ack_b !== n_acks[0]) begin
          errors++;
          $display("FAIL held_order%0d: ack_b=%b (required %b)", n_acks, ack_b, n_acks[0]);
        end
        if (n_acks > 0) begin
          checks++;
          if (cyc - last_cyc != (last_id ? 5 : 4)) begin
            errors++;
            $display("FAIL held_gap%0d: gap=%0d (required %0d)", n_acks, cyc - last_cyc,
                     last_id ? 5 : 4);
          end
        end
        last_cyc = cyc;
        last_id = ack_b;
        n_acks++;
      end
      if (n_acks < 4) @(negedge clk);
    end
    checks++;
    if (n_acks != 4) begin
      errors++;
      $display("FAIL held_count: acks=%0d (required 4)", n_acks);
    end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got || done_id !== 1'b1 || q !== 8'hF0) begin
      errors++;
      $display("FAIL held_last_done: done=%b id=%b q=%h (required 1 1 F0)", done, done_id, q);
    end
    @(negedge clk);
  endtask

  task automatic test_empty;
    int done_seen = 0;
    run_op(1'b0, 2'b01, 8'hFF, 4'd0);
    run_op(1'b0, 2'b10, 8'h3C, 4'd0);
    @(negedge clk);
    req_a = 1'b1; op_a = 2'b01; mask_a = 8'h00; len_a = 4'd15;
    #1;
    checks++;
    if (ack_a !== 1'b1 || q !== 8'h3C) begin
      errors++;
      $display("FAIL empty_ack: ack_a=%b q=%h (required 1 3C)", ack_a, q);
    end
    @(negedge clk);
    req_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if ({j, k, q, busy, done} !== {8'h00, 8'h00, 8'h3C, 2'b10}) begin
        errors++;
        $display("FAIL empty_apply%0d: j=%h k=%h q=%h busy=%b done=%b (required 00 00 3C 1 0)",
                 i, j, k, q, busy, done);
      end
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (done !== 1'b1 || done_id !== 1'b0 || q !== 8'h3C) begin
      errors++;
      $display("FAIL empty_done: done=%b id=%b q=%h (required 1 0 3C)", done, done_id, q);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_seen != 0) begin
      errors++;
      $display("FAIL empty_after: done=%b busy=%b early=%0d (required 0 0 0)",
               done, busy, done_seen);
    end
  endtask

  task automatic test_abort;
    bit got;
    @(negedge clk);
    req_b = 1'b1; op_b = 2'b10; mask_b = 8'hFF; len_b = 4'd7;
    #1;
    checks++;
    if (ack_b !== 1'b1) begin
      errors++;
      $display("FAIL abort_ack: ack_b=%b (required 1)", ack_b);
    end
    @(negedge clk);
    req_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q !== 8'hFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: q=%h busy=%b (required FF 1)", q, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({q, busy, done} !== {8'h00, 2'b00}) begin
      errors++;
      $display("FAIL abort_clear: q=%h busy=%b done=%b (required 00 0 0)", q, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h00) begin
        errors++;
        $display("FAIL abort_quiet%0d: done=%b busy=%b q=%h (required 0 0 00)",
                 i, done, busy, q);
      end
    end
    op_a = 2'b10; mask_a = 8'h81; len_a = 4'd0;
    op_b = 2'b10; mask_b = 8'h18; len_b = 4'd0;
    req_a = 1'b1; req_b = 1'b1;
    #1;
    checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL abort_tie: ack_a=%b ack_b=%b (required 1 0)", ack_a, ack_b);
    end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got || done_id !== 1'b0 || q !== 8'h81) begin
      errors++;
      $display("FAIL abort_next: done=%b id=%b q=%h (required 1 0 81)", done, done_id, q);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    req_a = 1'b0; op_a = 2'b00; mask_a = 8'h00; len_a = 4'd0;
    req_b = 1'b0; op_b = 2'b00; mask_b = 8'h00; len_b = 4'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_set();
    test_toggle();
    test_held();
    test_empty();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
